macrocell_configuration_encoder: RTL
====================================

Name: macrocell_configuration_encoder

Overview:
- Builds the macrocell configuration block of a bitstream from per-macrocell field values. It is the write side of the macrocell configuration decoder.
- Accepts one macrocell's fields per handshake, in bitstream order: lab A macrocell 1 first, then through the last lab's last macrocell.
- Packs each macrocell into a fixed word and streams the block out serially, LSB (block bit 0) first, under valid/ready flow control.
- Sits between the fitter-result loader and the bitstream assembler.

Parameters:
num_labs, 2, number of LABs in the block
macrocells_per_lab, 16, macrocells per LAB
product_terms_per_macrocell, 5, width of product_term_enable
bits_per_macrocell, product_terms_per_macrocell+9, packed word width (14 by default); fixed by field layout and not overridden
size_configuration_block, num_labs*macrocells_per_lab*bits_per_macrocell, total serial bits per frame (448 by default)

Ports:
clock  input  1  sole clock; all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  begin a frame; honoured only in IDLE
busy  output  1  high from accepted start until frame_done
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
product_term_enable  input  product_terms_per_macrocell  word bits [P-1:0]
clear_select  input  1  word bit P
enable_preset  input  1  word bit P+1
clock_and_enable_switch  input  2  word bits [P+3:P+2]
fast_input_select  input  1  word bit P+4
parallel_expander_enable  input  3  word bits [P+7:P+5]
register_bypass_enable  input  1  word bit P+8
serial_data  output  1  current configuration bit
serial_valid  output  1  serial_data valid
serial_ready  input  1  downstream consumes bit when high with serial_valid
current_lab  output  clog2(num_labs)  0-based LAB index of the word in flight
current_macrocell  output  clog2(macrocells_per_lab)  0-based macrocell index within the LAB
frame_done  output  1  one-cycle pulse after the final bit is consumed

Behaviour:
- P = product_terms_per_macrocell.
- Block bit index = (lab*macrocells_per_lab + macrocell)*bits_per_macrocell + word bit.
- States:
  - IDLE: start -> LOAD, with counters cleared and busy=1.
  - LOAD: in_ready=1. An in_valid&in_ready handshake latches the packed word into the shift register, clears the bit counter, and moves to SHIFT.
  - SHIFT: serial_valid=1 and serial_data=shreg[0].
    - Each serial_valid&serial_ready handshake shifts right by one and increments the bit counter.
    - On the handshake of bit bits_per_macrocell-1: if this is the last macrocell of the last LAB, go to DONE. Otherwise go to LOAD with current_macrocell incremented; at macrocells_per_lab-1 it wraps to 0 and current_lab increments.
  - DONE: for one cycle frame_done=1 and busy stays 1; the next state is IDLE with busy=0.
- Latency: a word accepted in cycle N presents its bit 0 in cycle N+1. There is exactly one LOAD bubble between words, so a frame takes at least size_configuration_block + num_labs*macrocells_per_lab + 1 cycles after start.
- serial_ready low holds serial_data and all state. in_valid is ignored outside LOAD. start is ignored unless in IDLE, including start asserted in the same cycle as frame_done.
- All outputs are registered, except in_ready and serial_valid, which decode directly from state.
- Reset, including mid-frame: state=IDLE; busy, in_ready, serial_valid, serial_data and frame_done are 0; all counters and the shift register are 0. A partial frame is discarded with no frame_done.
- Fields are packed verbatim, with no legality checking. Undriven or X inputs are the caller's responsibility.

Test Plan:
- Default params; start, then 32 bundles each carrying 14 bits = 0x2A5A ^ index, with serial_ready held 1 -> exactly 448 serial bits equal to the concatenated words LSB-first; frame_done pulses once, 1 cycle after bit 447; total 481 cycles after start.
- Word 0 with product_term_enable=5'b10110 and all other fields 0 -> serial bits 0..13 = 0,1,1,0,1,0,...,0.
- Word 0 with register_bypass_enable=1 only -> bit 13 = 1, bits 0..12 = 0.
- Toggle serial_ready 1,0,0,1 repeatedly -> bit sequence identical to the no-stall run; serial_data stable while stalled; current_lab/current_macrocell go 0/15 -> 1/0 at the 16th word boundary.
- Pulse start while busy, and drive in_valid while in IDLE -> no effect; busy stays 1, no bundle is accepted, and the frame output is unchanged.
- Assert reset at bit 200 -> the next cycle shows all outputs 0 and state IDLE with no frame_done; a following start produces a clean 448-bit frame.

Source files
------------

// File: rtl/macrocell_configuration_encoder.sv
// Macrocell configuration encoder: takes one macrocell's field bundle per
// handshake, packs it into a fixed-width word and streams the words out
// serially, LSB first, to build the macrocell configuration block of a frame.
module macrocell_configuration_encoder #(
  parameter int num_labs                    = 2,
  parameter int macrocells_per_lab          = 16,
  parameter int product_terms_per_macrocell = 5,
  localparam int bits_per_macrocell         = product_terms_per_macrocell + 9,
  localparam int lab_w = (num_labs > 1) ? $clog2(num_labs) : 1,
  localparam int mc_w  = (macrocells_per_lab > 1) ? $clog2(macrocells_per_lab) : 1,
  localparam int bit_w = $clog2(bits_per_macrocell + 1)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   busy,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [product_terms_per_macrocell-1:0] product_term_enable,
  input  logic                                   clear_select,
  input  logic                                   enable_preset,
  input  logic [1:0]                             clock_and_enable_switch,
  input  logic                                   fast_input_select,
  input  logic [2:0]                             parallel_expander_enable,
  input  logic                                   register_bypass_enable,
  output logic                                   serial_data,
  output logic                                   serial_valid,
  input  logic                                   serial_ready,
  output logic [lab_w-1:0]                       current_lab,
  output logic [mc_w-1:0]                        current_macrocell,
  output logic                                   frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                        state;
  logic [bits_per_macrocell-1:0] shreg;
  logic [bits_per_macrocell-1:0] packed_word;
  logic [bit_w-1:0]              bit_count;
  logic                          last_bit;
  logic                          last_macrocell_in_lab;
  logic                          last_lab;

  // Field layout of one macrocell word, bit 0 at the right.
  assign packed_word = {register_bypass_enable,
                        parallel_expander_enable,
                        fast_input_select,
                        clock_and_enable_switch,
                        enable_preset,
                        clear_select,
                        product_term_enable};

  assign last_bit              = (bit_count == bit_w'(bits_per_macrocell - 1));
  assign last_macrocell_in_lab = (current_macrocell == mc_w'(macrocells_per_lab - 1));
  assign last_lab              = (current_lab == lab_w'(num_labs - 1));

  // The handshake qualifiers come straight from the state so the upstream and
  // downstream see them in the same cycle the state is entered.
  assign in_ready     = (state == LOAD);
  assign serial_valid = (state == SHIFT);
  assign serial_data  = shreg[0];

  // Frame sequencer: accept a word, shift it out bit by bit, advance the
  // LAB/macrocell position, and pulse frame_done after the last bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      shreg             <= '0;
      bit_count         <= '0;
      current_lab       <= '0;
      current_macrocell <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state             <= LOAD;
            busy              <= 1'b1;
            bit_count         <= '0;
            current_lab       <= '0;
            current_macrocell <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            shreg     <= packed_word;
            bit_count <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (serial_ready) begin
            shreg     <= shreg >> 1;
            bit_count <= bit_count + 1'b1;
            if (last_bit) begin
              if (last_lab && last_macrocell_in_lab) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                state <= LOAD;
                if (last_macrocell_in_lab) begin
                  current_macrocell <= '0;
                  current_lab       <= current_lab + 1'b1;
                end else begin
                  current_macrocell <= current_macrocell + 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
